// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel-write arbiter: screen geometry,
// arbiter state encoding, pixel record and a visibility helper.
package vga_pkg;

    localparam int VGA_SCREEN_WIDTH  = 160;
    localparam int VGA_SCREEN_HEIGHT = 120;
    localparam int VGA_COLOR_DEPTH   = 9;
    localparam int VGA_NX            = 8;
    localparam int VGA_NY            = 7;

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [VGA_NX-1:0]          x;
        logic [VGA_NY-1:0]          y;
        logic [VGA_COLOR_DEPTH-1:0] color;
    } pixel_t;

    // Unsigned bounds check done at 32 bits so any coordinate width compares exactly.
    function automatic logic pix_visible(input logic [31:0] px, input logic [31:0] py,
                                         input logic [31:0] w,  input logic [31:0] h);
        pix_visible = (px < w) && (py < h);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority selector: returns the first set request
// found searching ptr, ptr+1, ... wrapping at N (not at a power of two).
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [PW-1:0] idx;
    logic          found;

    // Walk the requests starting at ptr and keep only the first hit.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx      = PW'((int'(ptr) + k) % N);
            gnt[idx] = req[idx] & ~found;
            found    = found | req[idx];
        end
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter sharing the vga_adapter pixel-write port between
// NUM_REQ producers, with per-requester burst lock and off-screen clipping.
// Optional build macro VGA_ARB_CLIP_COUNT_EN adds a saturating 16-bit
// count of clipped pixels on output clip_count.
module vga_write_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int nX            = VGA_NX,
    parameter int nY            = VGA_NY,
    parameter int COLOR_DEPTH   = VGA_COLOR_DEPTH,
    parameter int SCREEN_WIDTH  = VGA_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = VGA_SCREEN_HEIGHT
) (
    input  logic                           CLOCK_50,
    input  logic                           resetn,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_lock,
    input  logic [NUM_REQ*nX-1:0]          req_x,
    input  logic [NUM_REQ*nY-1:0]          req_y,
    input  logic [NUM_REQ*COLOR_DEPTH-1:0] req_color,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             grant,
    output logic [nX-1:0]                  x,
    output logic [nY-1:0]                  y,
    output logic [COLOR_DEPTH-1:0]         color,
    output logic                           write,
    output logic                           locked
`ifdef VGA_ARB_CLIP_COUNT_EN
    ,
    output logic [15:0]                    clip_count
`endif
);

    localparam int PW = $clog2(NUM_REQ);

    arb_state_e             state_q, state_d;
    logic [PW-1:0]          owner_q, owner_d;
    logic [PW-1:0]          ptr_q, ptr_d;

    logic [NUM_REQ-1:0]     rr_gnt_s;
    logic [NUM_REQ-1:0]     grant_s;
    logic                   accept_s;
    logic [PW-1:0]          win_s;
    logic [nX-1:0]          win_x_s;
    logic [nY-1:0]          win_y_s;
    logic [COLOR_DEPTH-1:0] win_color_s;
    logic                   visible_s;

    logic [nX-1:0]          x_q, x_d;
    logic [nY-1:0]          y_q, y_d;
    logic [COLOR_DEPTH-1:0] color_q, color_d;
    logic                   write_q, write_d;

    // Next round-robin start: one past p, wrapping at NUM_REQ.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(NUM_REQ - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + PW'(1);
        end
    endfunction

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (rr_gnt_s)
    );

    // Output decode: grant from state (gated off while reset is asserted).
    always_comb begin
        grant_s = '0;
        if (!resetn) begin
            grant_s = '0;
        end else begin
            case (state_q)
                ST_ARB:    grant_s = rr_gnt_s;
                ST_LOCKED: grant_s = req_valid[owner_q] ? (NUM_REQ'(1) << owner_q) : '0;
                default:   grant_s = '0;
            endcase
        end
    end

    assign req_ready = grant_s & req_valid;
    assign accept_s  = |req_ready;
    assign grant     = grant_s;

    // Encode the one-hot grant into the winner index.
    always_comb begin
        win_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_s = grant_s[i] ? PW'(i) : win_s;
        end
    end

    assign win_x_s     = req_x[int'(win_s)*nX +: nX];
    assign win_y_s     = req_y[int'(win_s)*nY +: nY];
    assign win_color_s = req_color[int'(win_s)*COLOR_DEPTH +: COLOR_DEPTH];
    assign visible_s   = pix_visible(32'(win_x_s), 32'(win_y_s),
                                     32'(SCREEN_WIDTH), 32'(SCREEN_HEIGHT));

    // Next-state logic for lock ownership and the round-robin pointer.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_ARB: begin
                if (accept_s) begin
                    if (req_lock[win_s]) begin
                        state_d = ST_LOCKED;
                        owner_d = win_s;
                    end else begin
                        ptr_d = ptr_inc(win_s);
                    end
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_LOCKED: begin
                // Lock low releases both on a final accepted beat and on an
                // idle owner; either way the others compete next cycle.
                if (!req_lock[owner_q]) begin
                    state_d = ST_ARB;
                    ptr_d   = ptr_inc(owner_q);
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // State register: arbiter state, lock owner and round-robin pointer.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_ARB;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Pixel datapath next values: capture the winner, hold when idle.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        write_d = 1'b0;
        if (accept_s) begin
            x_d     = win_x_s;
            y_d     = win_y_s;
            color_d = win_color_s;
            write_d = visible_s;
        end else begin
            write_d = 1'b0;
        end
    end

    // Registered pixel port toward vga_adapter.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            write_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            write_q <= write_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign color  = color_q;
    assign write  = write_q;
    assign locked = (state_q == ST_LOCKED);

`ifdef VGA_ARB_CLIP_COUNT_EN
    logic [15:0] clip_q, clip_d;

    // Saturating count of accepted pixels that fell off-screen.
    always_comb begin
        clip_d = clip_q;
        if (accept_s && !visible_s && (clip_q != 16'hFFFF)) begin
            clip_d = clip_q + 16'd1;
        end else begin
            clip_d = clip_q;
        end
    end

    // Clip counter register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clip_q <= 16'd0;
        end else begin
            clip_q <= clip_d;
        end
    end

    assign clip_count = clip_q;
`endif

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed, table-driven bench for vga_write_arbiter (NUM_REQ=3 defaults).
module tb_vga_write_arbiter;

    logic        CLOCK_50;
    logic        resetn;
    logic [2:0]  req_valid;
    logic [2:0]  req_lock;
    logic [23:0] req_x;
    logic [20:0] req_y;
    logic [26:0] req_color;
    logic [2:0]  req_ready;
    logic [2:0]  grant;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [8:0]  color;
    logic        write;
    logic        locked;
`ifdef VGA_ARB_CLIP_COUNT_EN
    logic [15:0] clip_count;
`endif

    logic [7:0] px [3];
    logic [6:0] py [3];
    logic [8:0] pc [3];

    assign req_x     = {px[2], px[1], px[0]};
    assign req_y     = {py[2], py[1], py[0]};
    assign req_color = {pc[2], pc[1], pc[0]};

    vga_write_arbiter dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_lock   (req_lock),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_color  (req_color),
        .req_ready  (req_ready),
        .grant      (grant),
        .x          (x),
        .y          (y),
        .color      (color),
        .write      (write),
        .locked     (locked)
`ifdef VGA_ARB_CLIP_COUNT_EN
        ,
        .clip_count (clip_count)
`endif
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int n_chk;
    int n_fail;

    typedef struct {
        logic [2:0] valid;
        logic [2:0] lock;
        logic [2:0] grant;
        logic       write;
        logic [7:0] x;
        logic [6:0] y;
        logic [8:0] color;
        logic       locked;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [2:0] l);
        @(negedge CLOCK_50);
        req_valid = v;
        req_lock  = l;
        #1;
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic set_default_pixels();
        px[0] = 8'd1;  py[0] = 7'd2;  pc[0] = 9'h001;
        px[1] = 8'd5;  py[1] = 7'd7;  pc[1] = 9'h1FF;
        px[2] = 8'd20; py[2] = 7'd30; pc[2] = 9'h0AA;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        // P0=(1,2,001) P1=(5,7,1FF) P2=(20,30,0AA)
        //            valid   lock    grant  wr    x      y      color   locked
        vecs[0]  = '{3'b010, 3'b000, 3'b010, 1'b1, 8'd5,  7'd7,  9'h1FF, 1'b0};
        vecs[1]  = '{3'b111, 3'b000, 3'b100, 1'b1, 8'd20, 7'd30, 9'h0AA, 1'b0};
        vecs[2]  = '{3'b111, 3'b000, 3'b001, 1'b1, 8'd1,  7'd2,  9'h001, 1'b0};
        vecs[3]  = '{3'b111, 3'b000, 3'b010, 1'b1, 8'd5,  7'd7,  9'h1FF, 1'b0};
        vecs[4]  = '{3'b111, 3'b000, 3'b100, 1'b1, 8'd20, 7'd30, 9'h0AA, 1'b0};
        vecs[5]  = '{3'b111, 3'b000, 3'b001, 1'b1, 8'd1,  7'd2,  9'h001, 1'b0};
        vecs[6]  = '{3'b111, 3'b000, 3'b010, 1'b1, 8'd5,  7'd7,  9'h1FF, 1'b0};
        vecs[7]  = '{3'b111, 3'b000, 3'b100, 1'b1, 8'd20, 7'd30, 9'h0AA, 1'b0};
        vecs[8]  = '{3'b000, 3'b000, 3'b000, 1'b0, 8'd20, 7'd30, 9'h0AA, 1'b0};
        vecs[9]  = '{3'b101, 3'b001, 3'b001, 1'b1, 8'd1,  7'd2,  9'h001, 1'b1};
        vecs[10] = '{3'b101, 3'b001, 3'b001, 1'b1, 8'd1,  7'd2,  9'h001, 1'b1};
        vecs[11] = '{3'b101, 3'b001, 3'b001, 1'b1, 8'd1,  7'd2,  9'h001, 1'b1};
        vecs[12] = '{3'b101, 3'b000, 3'b001, 1'b1, 8'd1,  7'd2,  9'h001, 1'b0};
        vecs[13] = '{3'b100, 3'b000, 3'b100, 1'b1, 8'd20, 7'd30, 9'h0AA, 1'b0};
        vecs[14] = '{3'b010, 3'b010, 3'b010, 1'b1, 8'd5,  7'd7,  9'h1FF, 1'b1};
        vecs[15] = '{3'b101, 3'b000, 3'b000, 1'b0, 8'd5,  7'd7,  9'h1FF, 1'b0};
        vecs[16] = '{3'b101, 3'b000, 3'b100, 1'b1, 8'd20, 7'd30, 9'h0AA, 1'b0};
        vecs[17] = '{3'b001, 3'b001, 3'b001, 1'b1, 8'd1,  7'd2,  9'h001, 1'b1};
        vecs[18] = '{3'b110, 3'b001, 3'b000, 1'b0, 8'd1,  7'd2,  9'h001, 1'b1};
        vecs[19] = '{3'b111, 3'b000, 3'b001, 1'b1, 8'd1,  7'd2,  9'h001, 1'b0};
        vecs[20] = '{3'b111, 3'b000, 3'b010, 1'b1, 8'd5,  7'd7,  9'h1FF, 1'b0};

        // Reset state, with all valids raised: nothing may be granted.
        set_default_pixels();
        resetn    = 1'b0;
        req_valid = 3'b111;
        req_lock  = 3'b000;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        #1;
        chk("rst grant",  32'(grant),     32'd0);
        chk("rst ready",  32'(req_ready), 32'd0);
        chk("rst write",  32'(write),     32'd0);
        chk("rst x",      32'(x),         32'd0);
        chk("rst y",      32'(y),         32'd0);
        chk("rst color",  32'(color),     32'd0);
        chk("rst locked", 32'(locked),    32'd0);
`ifdef VGA_ARB_CLIP_COUNT_EN
        chk("rst clip_count", 32'(clip_count), 32'd0);
`endif
        @(negedge CLOCK_50);
        req_valid = 3'b000;
        resetn    = 1'b1;

        // Table: single requester, round-robin, lock burst, idle release.
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].valid, vecs[i].lock);
            chk($sformatf("v%0d grant", i),  32'(grant),     32'(vecs[i].grant));
            chk($sformatf("v%0d ready", i),  32'(req_ready), 32'(vecs[i].grant & vecs[i].valid));
            tick();
            chk($sformatf("v%0d write", i),  32'(write),  32'(vecs[i].write));
            chk($sformatf("v%0d x", i),      32'(x),      32'(vecs[i].x));
            chk($sformatf("v%0d y", i),      32'(y),      32'(vecs[i].y));
            chk($sformatf("v%0d color", i),  32'(color),  32'(vecs[i].color));
            chk($sformatf("v%0d locked", i), 32'(locked), 32'(vecs[i].locked));
        end

        // Clipping: x=160,y=3 is off-screen, still accepted.
        px[1] = 8'd160; py[1] = 7'd3;
        drive(3'b010, 3'b000);
        chk("clip1 ready", 32'(req_ready), 32'b010);
        tick();
        chk("clip1 write", 32'(write), 32'd0);
        chk("clip1 x",     32'(x),     32'd160);
`ifdef VGA_ARB_CLIP_COUNT_EN
        chk("clip1 count", 32'(clip_count), 32'd1);
`endif
        // x=10,y=120 is off-screen vertically.
        px[1] = 8'd10; py[1] = 7'd120;
        drive(3'b010, 3'b000);
        chk("clip2 ready", 32'(req_ready), 32'b010);
        tick();
        chk("clip2 write", 32'(write), 32'd0);
        chk("clip2 y",     32'(y),     32'd120);
`ifdef VGA_ARB_CLIP_COUNT_EN
        chk("clip2 count", 32'(clip_count), 32'd2);
`endif
        // Last visible corner (159,119) is written.
        px[0] = 8'd159; py[0] = 7'd119;
        drive(3'b001, 3'b000);
        chk("edge ready", 32'(req_ready), 32'b001);
        tick();
        chk("edge write", 32'(write), 32'd1);
        chk("edge x",     32'(x),     32'd159);
        chk("edge y",     32'(y),     32'd119);
`ifdef VGA_ARB_CLIP_COUNT_EN
        chk("edge count", 32'(clip_count), 32'd2);
`endif
        // Max coordinates (255,127) are clipped.
        px[2] = 8'd255; py[2] = 7'd127;
        drive(3'b100, 3'b000);
        chk("max ready", 32'(req_ready), 32'b100);
        tick();
        chk("max write", 32'(write), 32'd0);
        chk("max x",     32'(x),     32'd255);
`ifdef VGA_ARB_CLIP_COUNT_EN
        chk("max count", 32'(clip_count), 32'd3);
`endif

        // Async reset mid-burst: move ptr to 2, lock requester 2, then reset.
        set_default_pixels();
        drive(3'b010, 3'b000);
        tick();
        drive(3'b100, 3'b100);
        chk("burst grant0", 32'(grant), 32'b100);
        tick();
        chk("burst write0",  32'(write),  32'd1);
        chk("burst locked0", 32'(locked), 32'd1);
        drive(3'b100, 3'b100);
        chk("burst grant1", 32'(grant), 32'b100);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst write",  32'(write),     32'd0);
        chk("arst locked", 32'(locked),    32'd0);
        chk("arst grant",  32'(grant),     32'd0);
        chk("arst ready",  32'(req_ready), 32'd0);
        @(negedge CLOCK_50);
        req_valid = 3'b111;
        req_lock  = 3'b000;
        resetn    = 1'b1;
        #1;
        chk("post rst grant", 32'(grant), 32'b001);
        tick();
        chk("post rst write", 32'(write), 32'd1);
        chk("post rst x",     32'(x),     32'd1);
        drive(3'b111, 3'b000);
        chk("post rst grant2", 32'(grant), 32'b010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_write_arbiter.md
Name: vga_write_arbiter

Overview:
- Shares the single pixel-write port of vga_adapter (x, y, color, write) between NUM_REQ independent pixel producers: screen painter, tile renderer, overlay/score renderer.
- Round-robin arbitration with optional per-requester burst lock, so a full-screen or full-tile paint is not interleaved with other producers.
- Clips pixels outside the visible screen; output is registered.
- Sits between the producers and vga_adapter in the top level.

Parameters:
- NUM_REQ, 3, number of requesters (2..8); index 0 is the screen painter.
- nX, 8, X coordinate width.
- nY, 7, Y coordinate width.
- COLOR_DEPTH, 9, pixel color width (9, 6 or 3).
- SCREEN_WIDTH, 160, visible columns.
- SCREEN_HEIGHT, 120, visible rows.

Ports:
- CLOCK_50  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  requester i presents a pixel.
- req_lock  in  NUM_REQ  requester i asks to keep the grant after the current beat.
- req_x  in  NUM_REQ*nX  flattened; requester i occupies bits [i*nX +: nX].
- req_y  in  NUM_REQ*nY  flattened, same packing.
- req_color  in  NUM_REQ*COLOR_DEPTH  flattened, same packing.
- req_ready  out  NUM_REQ  pixel of requester i accepted this cycle.
- grant  out  NUM_REQ  one-hot current winner; 0 when idle.
- x  out  nX  to vga_adapter.x.
- y  out  nY  to vga_adapter.y.
- color  out  COLOR_DEPTH  to vga_adapter.color.
- write  out  1  to vga_adapter.write.
- locked  out  1  a lock owner is held.

Behaviour:
- Reset (asynchronous, while resetn=0):
  - x, y, color = 0; write = 0; locked = 0.
  - Round-robin pointer ptr = 0; owner register cleared.
  - grant and req_ready are 0 because no owner is held and valids are ignored.
  - A reset during a burst drops the lock and any registered pending pixel.
- State machine:
  - IDLE/ARB (no owner): grant = first i with req_valid[i], searching ptr, ptr+1, … modulo NUM_REQ.
  - LOCKED (owner o): grant = one-hot(o) whenever req_valid[o]=1, otherwise 0. Other requesters stall even if valid.
- Handshake:
  - req_ready = grant & req_valid. This is combinational from req_valid and state, with no combinational loop through req_ready.
  - A beat is accepted when req_valid[i] & req_ready[i].
  - At most one accept per cycle, so throughput is 1 pixel/clk.
  - A producer holds x, y, color and valid stable until it is accepted.
- Lock transitions, evaluated on an accept by winner w:
  - ARB and req_lock[w]=1 → LOCKED with o=w.
  - ARB and req_lock[w]=0 → stay ARB; ptr = (w+1) mod NUM_REQ.
  - LOCKED, accept with req_lock[o]=0 → ARB; ptr = (o+1) mod NUM_REQ.
  - LOCKED, req_valid[o]=0 and req_lock[o]=0 → ARB next cycle; ptr = (o+1) mod NUM_REQ. This is the idle release.
- Output, with latency 1 cycle from accept:
  - x, y, color are registered from the winner's fields.
  - write = 1 only if x < SCREEN_WIDTH and y < SCREEN_HEIGHT.
  - Out-of-range pixels are still accepted (req_ready=1) but produce write=0. These are clipped.
  - When there is no accept, write = 0 and x, y, color hold their last values.
- Widths:
  - Bounds compares are unsigned at full nX/nY width.
  - The ptr increment wraps at NUM_REQ, not at a power of two.
- Simultaneous events:
  - All requesters valid in ARB: the winner is the nearest index at or after ptr.
  - Lock owner releasing while others are valid: the others are arbitrated in the next cycle, not the same cycle.

Optional Feature:
- Macro: VGA_ARB_CLIP_COUNT_EN.
- When defined, adds output clip_count (16 bits).
  - It increments on every accepted out-of-range pixel and saturates at 16'hFFFF.
  - It is cleared by reset.
- When undefined, the port and counter are absent, and clipping behaviour is otherwise identical.

Decomposition:
- Shared package vga_pkg holds:
  - SCREEN_WIDTH, SCREEN_HEIGHT and COLOR_DEPTH constants.
  - The arbiter state encoding (ST_ARB, ST_LOCKED).
  - A pixel struct/typedef {x, y, color}.
- One natural sub-module: rr_pick, a combinational round-robin priority selector.
  - Inputs: request vector and ptr.
  - Output: one-hot grant.

Test Plan:
- Single requester: req 1 valid with x=5, y=7, color=9'h1FF → req_ready[1]=1 the same cycle; the next cycle write=1, x=5, y=7, color=9'h1FF.
- Round-robin, NUM_REQ=3: all three valid continuously, no locks → grant sequence 0,1,2,0,1,2; write=1 every cycle after the first.
- Lock burst: req 0 locks for 4 beats, lock=0 on the 4th, while req 2 is valid throughout → grant 0,0,0,0, then 2. req 2 sees req_ready=0 for 4 cycles.
- Clipping: x=160, y=3 or x=10, y=120 → req_ready=1, write=0 the next cycle. With VGA_ARB_CLIP_COUNT_EN, clip_count goes 0→1→2.
- Idle release: owner 1 locked, then drops both valid and lock → locked=0 the next cycle; ptr=2, so with requests 0 and 2 both valid, req 2 wins.
- Async reset mid-burst: resetn low between clock edges while LOCKED with write=1 → write, locked and grant = 0 immediately. After release, arbitration restarts from ptr=0.
